// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS main control FSM
//
// Purpose : state encodings, opcode constants, datapath select constants and
//           the packed control word produced by the state decoder.
// Ports   : none (package).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state-to-control-word decoder
//
// Purpose : maps the current FSM state onto the datapath control word.
// Ports   : i_state  in  4-bit state encoding
//           o_ctrl   out packed control word (ctrl_t)
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.irwrite = 1'b1;
                o_ctrl.pcwrite = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_FOUR;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_DECODE: begin
                o_ctrl.alusrcb = ALUSRCB_IMMSH2;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_IMM;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: o_ctrl.iord = 1'b1;
            S_MEMWB: begin
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_B;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_B;
                o_ctrl.aluop   = ALUOP_SUB;
                o_ctrl.pcsrc   = PCSRC_ALUOUT;
                o_ctrl.branch  = 1'b1;
            end
            S_ADDIWB: o_ctrl.regwrite = 1'b1;
            S_JUMP: begin
                o_ctrl.pcsrc   = PCSRC_JUMP;
                o_ctrl.pcwrite = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_main_ctrl_fsm.sv
// rtl/mips_main_ctrl_fsm.sv - multicycle MIPS main control state machine
//
// Purpose : sequences fetch/decode/execute/memory/writeback and drives the
//           datapath muxes, write enables and the 2-bit ALU-op field.
// Ports   : i_clk, i_rst (async, active-high), i_op (IR[31:26]),
//           i_mem_ready (only with MIPS_CTRL_MEM_WAIT_EN defined),
//           o_pcwrite, o_branch, o_iord, o_memwrite, o_irwrite, o_regdst,
//           o_memtoreg, o_regwrite, o_alusrca, o_alusrcb[1:0], o_aluop[1:0],
//           o_pcsrc[1:0], o_illegal_op, o_state[3:0].
// Config  : MIPS_CTRL_MEM_WAIT_EN adds i_mem_ready; FETCH, MEMRD and MEMWR
//           then hold until memory is ready.
module mips_main_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
`ifdef MIPS_CTRL_MEM_WAIT_EN
    input  logic       i_mem_ready,
`endif
    input  logic [5:0] i_op,
    output logic       o_pcwrite,
    output logic       o_branch,
    output logic       o_iord,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_regwrite,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_aluop,
    output logic [1:0] o_pcsrc,
    output logic       o_illegal_op,
    output logic [3:0] o_state
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   mem_ready;
    logic   illegal;

`ifdef MIPS_CTRL_MEM_WAIT_EN
    assign mem_ready = i_mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .i_state (state_q),
        .o_ctrl  (ctrl)
    );

    // While FETCH waits on memory the IR and PC must not load early; the
    // JUMP-state pcwrite is never gated.
    logic fetch_gate;
    assign fetch_gate = (state_q != S_FETCH) || mem_ready;

    assign o_pcwrite    = ctrl.pcwrite & fetch_gate;
    assign o_irwrite    = ctrl.irwrite & fetch_gate;
    assign o_branch     = ctrl.branch;
    assign o_iord       = ctrl.iord;
    assign o_memwrite   = ctrl.memwrite;
    assign o_regdst     = ctrl.regdst;
    assign o_memtoreg   = ctrl.memtoreg;
    assign o_regwrite   = ctrl.regwrite;
    assign o_alusrca    = ctrl.alusrca;
    assign o_alusrcb    = ctrl.alusrcb;
    assign o_aluop      = ctrl.aluop;
    assign o_pcsrc      = ctrl.pcsrc;
    assign o_illegal_op = illegal;
    assign o_state      = state_q;

endmodule
